// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU writeback (port A) and the load writeback (port B), with a registered decoded write.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned STALL_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [ADDR_W-1:0]        a_addr,
  input  logic [DATA_W-1:0]        a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [ADDR_W-1:0]        b_addr,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     b_ready,
  output logic [(2**ADDR_W)-1:0]   wr_en,
  output logic [DATA_W-1:0]        wr_data,
  output logic [STALL_CNT_W-1:0]   stall_count
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic                   last_b_q, last_b_d;
  logic [NREG-1:0]        wr_en_q, wr_en_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  logic grant_a;
  logic grant_b;
  logic contention;

  always_comb begin
    // last_b_q names the port that yields on contention: 1 means B went last, so A wins.
    grant_a    = !reset && a_valid && (!b_valid || last_b_q);
    grant_b    = !reset && b_valid && (!a_valid || !last_b_q);
    contention = !reset && a_valid && b_valid;

    last_b_d      = last_b_q;
    wr_en_d       = '0;
    wr_data_d     = wr_data_q;
    stall_count_d = stall_count_q;

    if (grant_a) begin
      last_b_d  = 1'b0;
      wr_data_d = a_data;
      if (a_addr != '0) wr_en_d[a_addr] = 1'b1;
    end else if (grant_b) begin
      last_b_d  = 1'b1;
      wr_data_d = b_data;
      if (b_addr != '0) wr_en_d[b_addr] = 1'b1;
    end

    if (contention && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q      <= 1'b1;
      wr_en_q       <= '0;
      wr_data_q     <= '0;
      stall_count_q <= '0;
    end else begin
      last_b_q      <= last_b_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed vectors push the expected
// registered write for each cycle; a monitor pops and compares after every edge.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic [31:0] wr_en;
  logic [31:0] wr_data;
  logic [7:0]  stall_count;

  regfile_write_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .STALL_CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_valid(a_valid),
    .a_addr(a_addr),
    .a_data(a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_addr(b_addr),
    .b_data(b_data),
    .b_ready(b_ready),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] en;
    logic [31:0] d;
    bit          chk_d;
    int unsigned sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  function automatic logic [31:0] onehot(input int unsigned a);
    logic [31:0] v;
    v = '0;
    if (a != 0) v[a] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, check ready, queue the expected registered result.
  task automatic step(input bit rst,
                      input bit av, input int unsigned aa, input logic [31:0] ad,
                      input bit bv, input int unsigned ba, input logic [31:0] bd,
                      input bit ear, input bit ebr,
                      input logic [31:0] een, input logic [31:0] ed, input bit chk,
                      input int unsigned esc);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    a_valid = av;  a_addr = 5'(aa);  a_data = ad;
    b_valid = bv;  b_addr = 5'(ba);  b_data = bd;
    #1;
    check("a_ready", {31'd0, a_ready}, {31'd0, ear});
    check("b_ready", {31'd0, b_ready}, {31'd0, ebr});
    e.en = een; e.d = ed; e.chk_d = chk; e.sc = esc;
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic idle(input logic [31:0] ed, input bit chk, input int unsigned esc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, ed, chk, esc);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, 1, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_en", wr_en, e.en);
          if (e.chk_d) check("wr_data", wr_data, e.d);
          check("stall_count", {24'd0, stall_count}, e.sc);
        end else begin
          check("wr_en_idle", wr_en, '0);
        end
      end
    end
  end

  initial begin : watchdog
    #100us;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int unsigned ai, bi, aa, ba, esc;
    logic [31:0] ad, bd;

    do_reset();
    // Valid under reset: no ready, no write, no contention counted.
    step(1, 1, 9, 32'h99, 1, 2, 32'h22, 0, 0, '0, '0, 1, 0);

    // Single A write, then hold.
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, onehot(5), 32'hDEADBEEF, 1, 0);
    idle(32'hDEADBEEF, 1, 0);

    // First contention after reset: A then B.
    do_reset();
    step(0, 1, 3, 32'h11, 1, 7, 32'h22, 1, 0, onehot(3), 32'h11, 1, 1);
    step(0, 0, 0, 0,      1, 7, 32'h22, 0, 1, onehot(7), 32'h22, 1, 1);
    idle(32'h22, 1, 1);

    // Six cycles of contention with fresh data for each winner.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ai = (i + 1) / 2;  bi = i / 2;
      aa = 10 + ai;      ba = 20 + bi;
      ad = 32'hA0 + ai;  bd = 32'hB0 + bi;
      if (i % 2 == 0)
        step(0, 1, aa, ad, 1, ba, bd, 1, 0, onehot(aa), ad, 1, i + 1);
      else
        step(0, 1, aa, ad, 1, ba, bd, 0, 1, onehot(ba), bd, 1, i + 1);
    end
    idle(32'hB2, 1, 6);

    // Address 0 is accepted but never enabled; pointer still advances.
    step(0, 1, 4, 32'h44, 0, 0, 0, 1, 0, onehot(4), 32'h44, 1, 6);
    step(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 1, '0, '0, 0, 6);
    step(0, 1, 12, 32'h55, 1, 13, 32'h66, 1, 0, onehot(12), 32'h55, 1, 7);

    // Reset in the cycle a write to register 9 is offered: nothing emerges.
    step(1, 1, 9, 32'h99, 0, 0, 0, 0, 0, '0, '0, 1, 0);
    idle('0, 1, 0);

    // 300 cycles of contention: counter saturates at 255.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ai = (i + 1) / 2;  bi = i / 2;
      aa = 1 + (ai % 15);  ba = 16 + (bi % 15);
      ad = 32'hA000_0000 + ai;  bd = 32'hB000_0000 + bi;
      esc = (i + 1 > 255) ? 255 : i + 1;
      if (i % 2 == 0)
        step(0, 1, aa, ad, 1, ba, bd, 1, 0, onehot(aa), ad, 1, esc);
      else
        step(0, 1, aa, ad, 1, ba, bd, 0, 1, onehot(ba), bd, 1, esc);
    end

    // Same-address contention: serialised, B's data lands last.
    step(0, 1, 8, 32'h1, 1, 8, 32'h2, 1, 0, onehot(8), 32'h1, 1, 255);
    step(0, 0, 0, 0,     1, 8, 32'h2, 0, 1, onehot(8), 32'h2, 1, 255);
    idle(32'h2, 1, 255);
    idle(32'h2, 1, 255);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
